// File: rtl/bit_wise_pkg.sv
// Shared definitions for the bit-wise shift blocks: fill-mode encoding and
// the helper that picks the bit shifted into vacated MSB positions.
package bit_wise_pkg;

    typedef enum logic {
        SHR_LOGICAL = 1'b0,
        SHR_ARITH   = 1'b1
    } shr_mode_e;

    // Logical shifts fill with zero; arithmetic shifts replicate the
    // operand's original sign bit.
    function automatic logic fill_bit(input shr_mode_e mode, input logic sign);
        return (mode == SHR_ARITH) && sign;
    endfunction

endpackage

// File: rtl/shift_right_stage.sv
// One pipeline stage of the right shifter: conditionally shifts by a fixed
// power-of-two distance, selected by one bit of the carried shift amount,
// and registers the result together with its sideband.
module shift_right_stage
    import bit_wise_pkg::*;
#(
    parameter int N     = 8,
    parameter int SHIFT = 1,
    parameter int O     = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    input  logic [O-1:0] in_b,
    input  logic         in_arith,
    input  logic         in_sign,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic [O-1:0] out_b,
    output logic         out_arith,
    output logic         out_sign
);

    localparam int BIT = $clog2(SHIFT);

    logic [N-1:0] shifted;
    logic         fill;

    // Shift by this stage's fixed distance when its bit of b is set.
    always_comb begin
        fill    = fill_bit(shr_mode_e'(in_arith), in_sign);
        shifted = in_data;
        if (in_b[BIT]) begin
            shifted = {{SHIFT{fill}}, in_data[N-1:SHIFT]};
        end
    end

    // Capture the shifted word and sideband whenever the stage may advance;
    // a bubble loads as valid=0 so empty slots collapse naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_b     <= '0;
            out_arith <= 1'b0;
            out_sign  <= 1'b0;
        end else if (load) begin
            out_valid <= in_valid;
            out_data  <= shifted;
            out_b     <= in_b;
            out_arith <= in_arith;
            out_sign  <= in_sign;
        end
    end

endmodule

// File: rtl/pipelined_bit_wise_shift_right.sv
// Pipelined barrel right shifter with valid/ready flow control. Stage k
// handles bit k of the shift amount; results emerge O cycles after accept
// when the output is not back-pressured.
module pipelined_bit_wise_shift_right
    import bit_wise_pkg::*;
#(
    parameter int N = 8,
    parameter int O = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [O-1:0] b,
    input  logic         arith,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c
);

    // Index 0 is the upstream input; index k+1 is the output of stage k.
    logic         stage_valid [0:O];
    logic [N-1:0] stage_data  [0:O];
    logic [O-1:0] stage_b     [0:O];
    logic         stage_arith [0:O];
    logic         stage_sign  [0:O];
    logic [O-1:0] stage_load;
    logic         downstream_free;
    logic         unused_tail;

    assign stage_valid[0] = in_valid;
    assign stage_data[0]  = a;
    assign stage_b[0]     = b;
    assign stage_arith[0] = arith;
    assign stage_sign[0]  = a[N-1];

    // A stage may load if any slot between it and the output is empty, or
    // the output is being drained this cycle.
    always_comb begin
        downstream_free = out_ready;
        stage_load      = '0;
        for (int k = O - 1; k >= 0; k--) begin
            downstream_free = downstream_free | ~stage_valid[k+1];
            stage_load[k]   = downstream_free;
        end
    end

    assign in_ready = stage_load[0];

    for (genvar k = 0; k < O; k++) begin : g_stage
        shift_right_stage #(
            .N     (N),
            .SHIFT (2 ** k),
            .O     (O)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (stage_load[k]),
            .in_valid  (stage_valid[k]),
            .in_data   (stage_data[k]),
            .in_b      (stage_b[k]),
            .in_arith  (stage_arith[k]),
            .in_sign   (stage_sign[k]),
            .out_valid (stage_valid[k+1]),
            .out_data  (stage_data[k+1]),
            .out_b     (stage_b[k+1]),
            .out_arith (stage_arith[k+1]),
            .out_sign  (stage_sign[k+1])
        );
    end

    assign out_valid = stage_valid[O];
    assign c         = stage_data[O];

    // The last stage's sideband has no consumer.
    assign unused_tail = ^{stage_b[O], stage_arith[O], stage_sign[O]};

endmodule

// File: tb/tb_pipelined_bit_wise_shift_right.sv
// Self-checking bench for pipelined_bit_wise_shift_right (N=8, O=3):
// directed vectors, backpressure, random streaming and mid-flight reset,
// all scored against a plain-arithmetic reference model.
module tb_pipelined_bit_wise_shift_right;

    localparam int N = 8;
    localparam int O = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [O-1:0] b;
    logic         arith;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;

    int check_count;
    int pass_count;
    int accepted;
    int received;

    logic         s_in_ready;
    logic         s_out_valid;
    logic [N-1:0] s_c;
    logic         prev_stall;
    logic [N-1:0] prev_c;

    logic [N-1:0] expected_q [$];

    logic [N-1:0] vec_a [0:63];
    logic [O-1:0] vec_b [0:63];
    logic         vec_m [0:63];

    pipelined_bit_wise_shift_right #(.N(N), .O(O)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case anything stalls indefinitely.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain shift operators on the original operand.
    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] av, input logic [O-1:0] bv,
                                               input logic mv);
        logic signed [N-1:0] sa;
        sa = av;
        if (mv) return sa >>> bv;
        return av >> bv;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Drive one cycle of inputs at the falling edge, sample after settling,
    // score any handshakes that the next rising edge will complete.
    task automatic applyStimulus(input logic v, input logic [N-1:0] av, input logic [O-1:0] bv,
                                 input logic mv, input logic ordy);
        logic [N-1:0] exp_c;
        in_valid  = v;
        a         = av;
        b         = bv;
        arith     = mv;
        out_ready = ordy;
        #1;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_c         = c;
        if (prev_stall) begin
            checkOutput("hold_out_valid", 32'(s_out_valid), 32'd1);
            checkOutput("hold_c", 32'(s_c), 32'(prev_c));
        end
        if (s_out_valid && ordy) begin
            if (expected_q.size() == 0) begin
                checkOutput("spurious_out_valid", 32'(s_out_valid), 32'd0);
            end else begin
                exp_c = expected_q.pop_front();
                checkOutput("scoreboard_c", 32'(s_c), 32'(exp_c));
                received++;
            end
        end
        if (v && s_in_ready) begin
            expected_q.push_back(ref_shift(av, bv, mv));
            accepted++;
        end
        prev_stall = s_out_valid && !ordy;
        prev_c     = s_c;
        @(negedge clk);
    endtask

    // Send one vector into an empty pipeline and check latency and value.
    task automatic sendDirected(input string tag, input logic [N-1:0] av, input logic [O-1:0] bv,
                                input logic mv, input logic [N-1:0] exp_c);
        applyStimulus(1'b1, av, bv, mv, 1'b1);
        checkOutput({tag, "_accept"}, 32'(s_in_ready), 32'd1);
        for (int i = 0; i < O - 1; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
            checkOutput({tag, "_early_valid"}, 32'(s_out_valid), 32'd0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput({tag, "_latency"}, 32'(s_out_valid), 32'd1);
        checkOutput({tag, "_c"}, 32'(s_c), 32'(exp_c));
    endtask

    initial begin
        int sent;
        int base;
        int cycles;
        logic ordy;

        check_count = 0;
        pass_count  = 0;
        accepted    = 0;
        received    = 0;
        prev_stall  = 1'b0;
        prev_c      = '0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        arith       = 1'b0;
        out_ready   = 1'b0;

        // Reset state.
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_c", 32'(c), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Directed vectors.
        sendDirected("b4_lsr3", 8'hB4, 3'd3, 1'b0, 8'h16);
        sendDirected("b4_asr3", 8'hB4, 3'd3, 1'b1, 8'hF6);
        sendDirected("80_asr7", 8'h80, 3'd7, 1'b1, 8'hFF);
        sendDirected("80_lsr7", 8'h80, 3'd7, 1'b0, 8'h01);
        sendDirected("5a_lsr0", 8'h5A, 3'd0, 1'b0, 8'h5A);
        sendDirected("5a_asr0", 8'h5A, 3'd0, 1'b1, 8'h5A);

        // Backpressure: 5 inputs offered while the output is stalled.
        for (int i = 0; i < 5; i++) begin
            vec_a[i] = 8'($urandom);
            vec_b[i] = 3'($urandom);
            vec_m[i] = 1'($urandom);
        end
        sent = 0;
        base = received;
        for (int cyc = 0; cyc < 6; cyc++) begin
            applyStimulus(sent < 5, vec_a[sent < 5 ? sent : 0], vec_b[sent < 5 ? sent : 0],
                          vec_m[sent < 5 ? sent : 0], 1'b0);
            if (sent < 5 && s_in_ready) sent++;
        end
        checkOutput("bp_accepted", 32'(sent), 32'd3);
        checkOutput("bp_in_ready_full", 32'(s_in_ready), 32'd0);
        checkOutput("bp_out_valid", 32'(s_out_valid), 32'd1);
        cycles = 0;
        while ((received - base) < 5 && cycles < 40) begin
            applyStimulus(sent < 5, vec_a[sent < 5 ? sent : 0], vec_b[sent < 5 ? sent : 0],
                          vec_m[sent < 5 ? sent : 0], 1'b1);
            if (cycles == 0) checkOutput("full_drain_accept", 32'(s_in_ready), 32'd1);
            if (sent < 5 && s_in_ready) sent++;
            cycles++;
        end
        checkOutput("bp_results", 32'(received - base), 32'd5);
        checkOutput("bp_queue_empty", 32'(expected_q.size()), 32'd0);

        // Random streaming with random output backpressure.
        for (int i = 0; i < 64; i++) begin
            vec_a[i] = 8'($urandom);
            vec_b[i] = 3'($urandom_range(0, 7));
            vec_m[i] = 1'($urandom);
        end
        sent   = 0;
        base   = received;
        cycles = 0;
        while ((received - base) < 64 && cycles < 2000) begin
            ordy = ($urandom_range(0, 3) != 0);
            applyStimulus(sent < 64, vec_a[sent < 64 ? sent : 0], vec_b[sent < 64 ? sent : 0],
                          vec_m[sent < 64 ? sent : 0], ordy);
            if (sent < 64 && s_in_ready) sent++;
            cycles++;
        end
        checkOutput("stream_results", 32'(received - base), 32'd64);
        checkOutput("stream_queue_empty", 32'(expected_q.size()), 32'd0);

        // Reset with three results in flight.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'($urandom) | 8'h01, 3'd1, 1'b0, 1'b0);
        end
        checkOutput("inflight_count", 32'(expected_q.size()), 32'd3);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_c", 32'(c), 32'd0);
        expected_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
            checkOutput("post_reset_no_stale", 32'(s_out_valid), 32'd0);
        end
        checkOutput("post_reset_ready", 32'(s_in_ready), 32'd1);
        sendDirected("after_reset", 8'hC3, 3'd2, 1'b1, ref_shift(8'hC3, 3'd2, 1'b1));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
